// File: rtl/rsc_term_encoder.sv
// LTE turbo RSC constituent encoder: programmable block length, valid-qualified input,
// 3-cycle trellis termination. Define RSC_DUAL_EN for the second (interleaved) channel.
module rsc_term_encoder #(
  parameter int KW   = 13,
  parameter int KMAX = 6144
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          ck,
`ifdef RSC_DUAL_EN
  input  logic          ck2,
`endif
  input  logic          ck_valid,
  output logic          xk,
  output logic          zk,
`ifdef RSC_DUAL_EN
  output logic          xk2,
  output logic          zk2,
`endif
  output logic          out_valid,
  output logic          tail,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    dd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_TAIL = 2'd2
  } state_e;

  localparam logic [KW-1:0] KMIN_C = KW'(40);
  localparam logic [KW-1:0] KMAX_C = KW'(KMAX);

  // One trellis step; returns {x, z, next {q2,q1,q0}}. In tail mode the input is fb so s = 0.
  function automatic logic [4:0] rsc_step(input logic [2:0] q, input logic tail_mode,
                                          input logic din);
    logic fb;
    logic s;
    logic x;
    logic z;
    fb = q[1] ^ q[2];
    s  = tail_mode ? 1'b0 : (din ^ fb);
    x  = tail_mode ? fb : din;
    z  = s ^ q[0] ^ q[2];
    return {x, z, q[1], q[0], s};
  endfunction

  state_e        state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] klen_q, klen_d;
  logic [1:0]    tcnt_q, tcnt_d;
  logic [2:0]    sr_q, sr_d;
  logic          xk_q, xk_d, zk_q, zk_d;
  logic          ov_q, ov_d, tail_q, tail_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          k_ok_s;
  logic          in_tail_s;
  logic [4:0]    step1_s;
`ifdef RSC_DUAL_EN
  logic [2:0]    sr2_q, sr2_d;
  logic          xk2_q, xk2_d, zk2_q, zk2_d;
  logic [4:0]    step2_s;
`endif

  always_comb begin
    k_ok_s    = (k_len >= KMIN_C) && (k_len <= KMAX_C);
    in_tail_s = (state_q == S_TAIL);
    step1_s   = rsc_step(sr_q, in_tail_s, ck);
`ifdef RSC_DUAL_EN
    step2_s   = rsc_step(sr2_q, in_tail_s, ck2);
    sr2_d     = sr2_q;
    xk2_d     = xk2_q;
    zk2_d     = zk2_q;
`endif
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    tcnt_d  = tcnt_q;
    sr_d    = sr_q;
    xk_d    = xk_q;
    zk_d    = zk_q;
    busy_d  = busy_q;
    ov_d    = 1'b0;
    tail_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_ok_s) begin
            state_d = S_DATA;
            klen_d  = k_len;
            cnt_d   = {KW{1'b0}};
            tcnt_d  = 2'd0;
            sr_d    = 3'b000;
`ifdef RSC_DUAL_EN
            sr2_d   = 3'b000;
`endif
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (ck_valid) begin
          ov_d  = 1'b1;
          xk_d  = step1_s[4];
          zk_d  = step1_s[3];
          sr_d  = step1_s[2:0];
`ifdef RSC_DUAL_EN
          xk2_d = step2_s[4];
          zk2_d = step2_s[3];
          sr2_d = step2_s[2:0];
`endif
          cnt_d = cnt_q + KW'(1);
          if ((cnt_q + KW'(1)) == klen_q) begin
            state_d = S_TAIL;
            tcnt_d  = 2'd0;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          ov_d = 1'b0;
        end
      end
      S_TAIL: begin
        ov_d   = 1'b1;
        tail_d = 1'b1;
        xk_d   = step1_s[4];
        zk_d   = step1_s[3];
        sr_d   = step1_s[2:0];
`ifdef RSC_DUAL_EN
        xk2_d  = step2_s[4];
        zk2_d  = step2_s[3];
        sr2_d  = step2_s[2:0];
`endif
        tcnt_d = tcnt_q + 2'd1;
        if (tcnt_q == 2'd2) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_TAIL;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= S_IDLE;
      cnt_q   <= {KW{1'b0}};
      klen_q  <= {KW{1'b0}};
      tcnt_q  <= 2'd0;
      sr_q    <= 3'b000;
      xk_q    <= 1'b0;
      zk_q    <= 1'b0;
      ov_q    <= 1'b0;
      tail_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef RSC_DUAL_EN
      sr2_q   <= 3'b000;
      xk2_q   <= 1'b0;
      zk2_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      tcnt_q  <= tcnt_d;
      sr_q    <= sr_d;
      xk_q    <= xk_d;
      zk_q    <= zk_d;
      ov_q    <= ov_d;
      tail_q  <= tail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef RSC_DUAL_EN
      sr2_q   <= sr2_d;
      xk2_q   <= xk2_d;
      zk2_q   <= zk2_d;
`endif
    end
  end

  assign xk        = xk_q;
  assign zk        = zk_q;
  assign out_valid = ov_q;
  assign tail      = tail_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dd        = sr_q;
`ifdef RSC_DUAL_EN
  assign xk2       = xk2_q;
  assign zk2       = zk2_q;
`endif

endmodule

// File: tb/tb_rsc_term_encoder.sv
// Self-checking bench for rsc_term_encoder: randomized blocks against a recurrence-based
// reference model, length rejection, mid-block start and asynchronous clear.
module tb_rsc_term_encoder;
  localparam int KW   = 13;
  localparam int KMAX = 6144;
  localparam int NB   = KMAX + 3;

  typedef bit bitarr_t [NB];

  logic          clk = 1'b0;
  logic          aclr, start, ck, ck_valid;
  logic [KW-1:0] k_len;
  logic          xk, zk, out_valid, tail, busy, done, err;
  logic [2:0]    dd;
`ifdef RSC_DUAL_EN
  logic          ck2, xk2, zk2;
`endif

  rsc_term_encoder #(.KW(KW), .KMAX(KMAX)) dut (
    .clk(clk), .aclr(aclr), .start(start), .k_len(k_len), .ck(ck),
`ifdef RSC_DUAL_EN
    .ck2(ck2),
`endif
    .ck_valid(ck_valid), .xk(xk), .zk(zk),
`ifdef RSC_DUAL_EN
    .xk2(xk2), .zk2(zk2),
`endif
    .out_valid(out_valid), .tail(tail), .busy(busy), .done(done), .err(err), .dd(dd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bitarr_t d1, d2, ex1, ez1, ex2, ez2;
  bit last_x1 = 1'b0, last_z1 = 1'b0, last_x2 = 1'b0, last_z2 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: feedback sequence a[n] = u[n] ^ a[n-2] ^ a[n-3], parity z[n] = a[n] ^ a[n-1] ^ a[n-3];
  // the three tail steps force a[n] = 0 and emit the feedback as the systematic bit.
  function automatic void ref_enc(input int k, input bitarr_t d, output bitarr_t ex,
                                  output bitarr_t ez);
    bitarr_t a;
    for (int n = 0; n < k + 3; n++) begin
      bit a1, a2, a3;
      a1 = (n >= 1) ? a[n-1] : 1'b0;
      a2 = (n >= 2) ? a[n-2] : 1'b0;
      a3 = (n >= 3) ? a[n-3] : 1'b0;
      if (n < k) begin
        a[n]  = d[n] ^ a2 ^ a3;
        ex[n] = d[n];
      end else begin
        a[n]  = 1'b0;
        ex[n] = a2 ^ a3;
      end
      ez[n] = a[n] ^ a1 ^ a3;
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_xk"}, xk, 0);
    check({tag, "_zk"}, zk, 0);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_tail"}, tail, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_dd"}, dd, 0);
`ifdef RSC_DUAL_EN
    check({tag, "_xk2"}, xk2, 0);
    check({tag, "_zk2"}, zk2, 0);
`endif
  endtask

  task automatic reject(input int k);
    k_len = KW'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rej_err_pulse", err, 1);
    check("rej_busy", busy, 0);
    check("rej_ov", out_valid, 0);
    tick();
    check("rej_err_clear", err, 0);
    check("rej_busy2", busy, 0);
    check("rej_ov2", out_valid, 0);
  endtask

  // dmode: 0 zeros, 1 impulse, 2 random. c2mode: 0 same as ck, 1 inverted, 2 random.
  task automatic run_block(input int k, input int dmode, input int gap_pct, input int c2mode,
                           input int abort_at, input bit mid_start);
    int sent, outn, ovc;
    for (int i = 0; i < k; i++) begin
      case (dmode)
        0:       d1[i] = 1'b0;
        1:       d1[i] = (i == 0);
        default: d1[i] = 1'($urandom_range(1));
      endcase
      case (c2mode)
        0:       d2[i] = d1[i];
        1:       d2[i] = ~d1[i];
        default: d2[i] = 1'($urandom_range(1));
      endcase
    end
    ref_enc(k, d1, ex1, ez1);
    ref_enc(k, d2, ex2, ez2);

    k_len    = KW'(k);
    start    = 1'b1;
    ck_valid = 1'b0;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ov_after_start", out_valid, 0);
    sent = 0;
    outn = 0;
    ovc  = 0;
    while (outn < k + 3) begin
      bit v;
      if (abort_at >= 0 && sent == abort_at) begin
        #2;
        aclr = 1'b1;
        #1;
        check_all_zero("aclr");
        aclr     = 1'b0;
        start    = 1'b0;
        ck_valid = 1'b0;
        last_x1 = 1'b0; last_z1 = 1'b0; last_x2 = 1'b0; last_z2 = 1'b0;
        return;
      end
      v = (sent < k) ? ($urandom_range(99) >= gap_pct) : 1'($urandom_range(1));
      ck_valid = v;
      ck = (sent < k && v) ? d1[sent] : 1'($urandom_range(1));
`ifdef RSC_DUAL_EN
      ck2 = (sent < k && v) ? d2[sent] : 1'($urandom_range(1));
`endif
      if (mid_start && $urandom_range(49) == 0) begin
        start = 1'b1;
        k_len = KW'(40);
      end else begin
        start = 1'b0;
      end
      tick();
      if (out_valid === 1'b1) ovc++;
      if (sent < k) begin
        if (v) begin
          check("data_ov", out_valid, 1);
          check("data_xk", xk, ex1[sent]);
          check("data_zk", zk, ez1[sent]);
          check("data_tail", tail, 0);
          check("data_done", done, 0);
`ifdef RSC_DUAL_EN
          check("data_xk2", xk2, ex2[sent]);
          check("data_zk2", zk2, ez2[sent]);
          last_x2 = ex2[sent]; last_z2 = ez2[sent];
`endif
          last_x1 = ex1[sent]; last_z1 = ez1[sent];
          sent++;
          outn++;
        end else begin
          check("gap_ov", out_valid, 0);
          check("gap_xk_hold", xk, last_x1);
          check("gap_zk_hold", zk, last_z1);
`ifdef RSC_DUAL_EN
          check("gap_xk2_hold", xk2, last_x2);
          check("gap_zk2_hold", zk2, last_z2);
`endif
        end
      end else begin
        check("tail_ov", out_valid, 1);
        check("tail_flag", tail, 1);
        check("tail_xk", xk, ex1[outn]);
        check("tail_zk", zk, ez1[outn]);
        check("tail_done", done, (outn == k + 2) ? 1 : 0);
`ifdef RSC_DUAL_EN
        check("tail_xk2", xk2, ex2[outn]);
        check("tail_zk2", zk2, ez2[outn]);
        last_x2 = ex2[outn]; last_z2 = ez2[outn];
`endif
        last_x1 = ex1[outn]; last_z1 = ez1[outn];
        outn++;
      end
      check("blk_err", err, 0);
      check("blk_busy", busy, (outn < k + 3) ? 1 : 0);
    end
    start    = 1'b0;
    ck_valid = 1'b0;
    check("ov_count", ovc, k + 3);
    check("dd_end", dd, 0);
    tick();
    check("post_done", done, 0);
    check("post_ov", out_valid, 0);
    check("post_tail", tail, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    aclr     = 1'b1;
    start    = 1'b0;
    ck       = 1'b0;
    ck_valid = 1'b0;
    k_len    = '0;
`ifdef RSC_DUAL_EN
    ck2      = 1'b0;
`endif
    #12;
    check_all_zero("reset");
    @(negedge clk);
    aclr = 1'b0;
    tick();
    check_all_zero("idle");

    run_block(40, 0, 0, 0, -1, 1'b0);
    run_block(40, 1, 0, 1, -1, 1'b0);
    reject(39);
    reject(6145);
    reject(0);
    run_block(6144, 2, 30, 2, -1, 1'b1);
    run_block(1056, 2, 10, 0, 500, 1'b0);
    run_block(40, 2, 20, 1, -1, 1'b1);
    run_block(100, 2, 50, 0, -1, 1'b1);
    reject(8191);
    run_block(41, 2, 0, 2, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
